// File: rtl/p2s_pkg.sv
// p2s_pkg: shared definitions for the round-robin parallel-to-serial scheduler.
//   P2S_N_DEF    : default bits per serial word
//   P2S_NREQ_DEF : default number of requesters
//   p2s_state_t  : scheduler FSM states
package p2s_pkg;

  localparam int P2S_N_DEF    = 8;
  localparam int P2S_NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } p2s_state_t;

endpackage

// File: rtl/p2s_rr_arb.sv
// p2s_rr_arb: combinational round-robin selector.
// Ports:
//   req       in  NREQ  pending requests
//   ptr       in  IW    index searched first; search wraps upward mod NREQ
//   gnt_valid out 1     at least one request pending
//   gnt_idx   out IW    first set request at or after ptr
module p2s_rr_arb
  import p2s_pkg::*;
#(
  parameter  int NREQ = P2S_NREQ_DEF,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  int w_j;

  // Walk from the farthest offset back to ptr so the closest set bit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (req[w_j[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/p2s_sched.sv
// p2s_sched: shares one serializer among NREQ requesters, round-robin.
// A word is granted only from IDLE, shifted out LSB first for N cycles, then
// one GAP cycle separates it from the next grant (word period N+2).
//
//   state | meaning
//   IDLE  | arbitrate; a pending request is granted at the end of this cycle
//   SHIFT | word in flight, one bit per cycle on d
//   GAP   | single dead cycle after the last bit
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   req          in   NREQ     per-requester word pending (level)
//   din          in   NREQ*N   requester i word at din[N*i +: N]
//   ack          out  NREQ     one-hot pulse in the first bit cycle
//   d            out  1        serial data, LSB first
//   serial_start out  1        first bit cycle
//   serial_end   out  1        last bit cycle
//   busy         out  1        all N bit cycles
//   owner        out  IW       requester whose word is on d
module p2s_sched
  import p2s_pkg::*;
#(
  parameter  int N    = P2S_N_DEF,
  parameter  int NREQ = P2S_NREQ_DEF,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] din,
  output logic [NREQ-1:0]   ack,
  output logic              d,
  output logic              serial_start,
  output logic              serial_end,
  output logic              busy,
  output logic [IW-1:0]     owner
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  p2s_state_t      r_state;
  logic [IW-1:0]   r_ptr;
  logic [N-1:0]    r_sh;
  logic [CW-1:0]   r_cnt;

  logic            w_gnt_valid;
  logic [IW-1:0]   w_gnt_idx;
  logic [N-1:0]    w_word;
  logic [IW-1:0]   w_ptr_next;

  p2s_rr_arb #(.NREQ(NREQ)) u_arb (
    .req       (req),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_word     = din[int'(w_gnt_idx)*N +: N];
  assign w_ptr_next = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + IW'(1);

  // Bit 0 goes straight to d at grant; r_sh keeps the remaining bits and
  // r_cnt is the index of the bit currently on d.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_sh         <= '0;
      r_cnt        <= '0;
      owner        <= '0;
      ack          <= '0;
      d            <= 1'b0;
      serial_start <= 1'b0;
      serial_end   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state      <= SHIFT;
            r_sh         <= w_word >> 1;
            r_cnt        <= '0;
            r_ptr        <= w_ptr_next;
            owner        <= w_gnt_idx;
            ack          <= NREQ'(1) << w_gnt_idx;
            d            <= w_word[0];
            serial_start <= 1'b1;
            serial_end   <= (N == 1);
            busy         <= 1'b1;
          end
        end
        SHIFT: begin
          ack          <= '0;
          serial_start <= 1'b0;
          if (r_cnt == LAST) begin
            r_state    <= GAP;
            d          <= 1'b0;
            serial_end <= 1'b0;
            busy       <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + CW'(1);
            d          <= r_sh[0];
            r_sh       <= r_sh >> 1;
            serial_end <= (r_cnt + CW'(1) == LAST);
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_sched.sv
module tb_p2s_sched;
  localparam int N    = 8;
  localparam int NREQ = 4;

  typedef struct {
    int         idx;
    logic [7:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] din = '0;
  logic [3:0]  ack;
  logic        d, serial_start, serial_end, busy;
  logic [1:0]  owner;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  exp_t sb[$];

  p2s_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .din          (din),
    .ack          (ack),
    .d            (d),
    .serial_start (serial_start),
    .serial_end   (serial_end),
    .busy         (busy),
    .owner        (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops the expected word at serial_start, rebuilds the
  // serial word and compares it at serial_end.
  exp_t       cur;
  bit         coll = 0;
  int         bcnt = 0;
  logic [7:0] bits = '0;

  always @(negedge clk) begin
    if (reset) begin
      coll = 0;
    end else if (busy) begin
      if (serial_start) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_expected: word started with no expected entry, owner=%0d", owner);
        end else begin
          n_pass++;
          cur  = sb.pop_front();
          coll = 1;
          bcnt = 0;
          bits = '0;
          n_total++;
          if (ack !== 4'(1 << cur.idx))
            $display("FAIL sb_ack: ack=%b expected %b", ack, 4'(1 << cur.idx));
          else n_pass++;
        end
      end else begin
        n_total++;
        if (!coll) $display("FAIL sb_busy_nostart: busy=1 without serial_start");
        else if (ack !== 4'b0) $display("FAIL sb_ack_late: ack=%b expected 0000", ack);
        else n_pass++;
      end
      if (coll) begin
        if (bcnt < 8) bits[bcnt] = d;
        bcnt++;
        if (serial_end) begin
          coll = 0;
          n_total++;
          if (bcnt !== N || bits !== cur.word || int'(owner) !== cur.idx)
            $display("FAIL sb_word: bits=%0d word=%h owner=%0d expected bits=%0d word=%h owner=%0d",
                     bcnt, bits, owner, N, cur.word, cur.idx);
          else n_pass++;
        end
      end
    end else begin
      n_total++;
      if (coll || d !== 1'b0 || ack !== 4'b0 || serial_start !== 1'b0 || serial_end !== 1'b0)
        $display("FAIL sb_idle: coll=%0d d=%b ack=%b start=%b end=%b expected all 0",
                 coll, d, ack, serial_start, serial_end);
      else n_pass++;
      coll = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (serial_start === 1'b1) begin
        at = cyc;
        break;
      end
    end
    n_total++;
    if (at < 0) $display("FAIL wait_start: no serial_start within %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'hF;
    din   = 32'hFFFF_FFFF;
    tick(2);
    n_total++;
    if ({d, busy, serial_start, serial_end} !== 4'b0 || ack !== 4'b0 || owner !== 2'd0)
      $display("FAIL reset_outputs: d=%b busy=%b start=%b end=%b ack=%b owner=%0d expected all 0",
               d, busy, serial_start, serial_end, ack, owner);
    else n_pass++;
    req = '0;
    din = '0;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single();
    logic [7:0] w;
    do_reset();
    w   = 8'hA5;
    din = '0;
    din[7:0] = w;
    req = 4'b0001;
    sb.push_back('{0, w});
    tick(1);
    n_total++;
    if (ack !== 4'b0001 || owner !== 2'd0)
      $display("FAIL single_ack: ack=%b owner=%0d expected 0001 owner=0", ack, owner);
    else n_pass++;
    req = '0;
    for (int k = 0; k < N; k++) begin
      n_total++;
      if (d !== w[k] || busy !== 1'b1 || serial_start !== (k == 0) || serial_end !== (k == N - 1))
        $display("FAIL single_bit%0d: d=%b busy=%b start=%b end=%b expected d=%b busy=1 start=%b end=%b",
                 k, d, busy, serial_start, serial_end, w[k], k == 0, k == N - 1);
      else n_pass++;
      tick(1);
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL single_gap: busy=%b expected 0", busy);
    else n_pass++;
    tick(2);
  endtask

  task automatic test_back_to_back();
    int at[5];
    do_reset();
    din = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'hF;
    for (int w = 0; w < 5; w++) sb.push_back('{w % 4, 8'(1 << (w % 4))});
    for (int w = 0; w < 5; w++) begin
      wait_start(20, at[w]);
      if (w == 4) req = '0;
      n_total++;
      if (int'(owner) !== w % 4) $display("FAIL rr_order%0d: owner=%0d expected %0d", w, owner, w % 4);
      else n_pass++;
    end
    for (int w = 1; w < 5; w++) begin
      n_total++;
      if (at[w] - at[w-1] !== N + 2)
        $display("FAIL rr_period%0d: spacing=%0d expected %0d", w, at[w] - at[w-1], N + 2);
      else n_pass++;
    end
    tick(N + 2);
  endtask

  task automatic test_ptr_priority();
    int at;
    do_reset();
    din[15:8] = 8'h66;
    req = 4'b0010;
    sb.push_back('{1, 8'h66});
    wait_start(5, at);
    req = '0;
    tick(1);
    din[7:0]  = 8'h11;
    din[15:8] = 8'h22;
    req = 4'b0011;
    sb.push_back('{0, 8'h11});
    sb.push_back('{1, 8'h22});
    wait_start(20, at);
    n_total++;
    if (owner !== 2'd0) $display("FAIL ptr_first: owner=%0d expected 0", owner);
    else n_pass++;
    req[0] = 1'b0;
    wait_start(20, at);
    n_total++;
    if (owner !== 2'd1) $display("FAIL ptr_second: owner=%0d expected 1", owner);
    else n_pass++;
    req = '0;
    tick(N + 2);
  endtask

  task automatic test_midword_change();
    int at;
    do_reset();
    din = '0;
    din[7:0] = 8'h3C;
    req = 4'b0001;
    sb.push_back('{0, 8'h3C});
    sb.push_back('{3, 8'h5A});
    wait_start(5, at);
    tick(2);
    req = 4'b1000;
    din[7:0]   = 8'hFF;
    din[31:24] = 8'h5A;
    wait_start(20, at);
    n_total++;
    if (owner !== 2'd3 || ack !== 4'b1000)
      $display("FAIL midword_next: owner=%0d ack=%b expected owner=3 ack=1000", owner, ack);
    else n_pass++;
    req = '0;
    tick(N + 2);
  endtask

  task automatic test_reset_midword();
    int at;
    do_reset();
    din = '0;
    din[15:8] = 8'hC3;
    req = 4'b0010;
    sb.push_back('{1, 8'hC3});
    wait_start(5, at);
    req = '0;
    tick(4);
    n_total++;
    if (busy !== 1'b1 || serial_end !== 1'b0)
      $display("FAIL abort_bit4: busy=%b end=%b expected busy=1 end=0", busy, serial_end);
    else n_pass++;
    reset = 1'b1;
    tick(1);
    n_total++;
    if ({d, busy, serial_start, serial_end} !== 4'b0 || ack !== 4'b0 || owner !== 2'd0)
      $display("FAIL abort_outputs: d=%b busy=%b start=%b end=%b ack=%b owner=%0d expected all 0",
               d, busy, serial_start, serial_end, ack, owner);
    else n_pass++;
    reset = 1'b0;
    din[23:16] = 8'h96;
    req = 4'b0100;
    sb.push_back('{2, 8'h96});
    wait_start(10, at);
    n_total++;
    if (owner !== 2'd2 || ack !== 4'b0100)
      $display("FAIL abort_next: owner=%0d ack=%b expected owner=2 ack=0100", owner, ack);
    else n_pass++;
    req = '0;
    tick(N + 2);
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_total++;
      if ({d, busy, serial_start, serial_end} !== 4'b0 || ack !== 4'b0)
        $display("FAIL idle_cycle%0d: d=%b busy=%b start=%b end=%b ack=%b expected all 0",
                 i, d, busy, serial_start, serial_end, ack);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ptr_priority();
    test_midword_change();
    test_reset_midword();
    test_idle();
    n_total++;
    if (sb.size() !== 0) $display("FAIL sb_drain: %0d expected words never seen, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
